// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, access modes, bit indices and trap causes
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Write/set/clear access modes
    typedef enum logic [1:0] {
        WSC_NONE  = 2'b00,
        WSC_WRITE = 2'b01,
        WSC_SET   = 2'b10,
        WSC_CLEAR = 2'b11
    } wsc_mode_e;

    // Bit positions inside mstatus, mie and mip
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MSI      = 3;
    localparam int IRQ_MTI      = 7;
    localparam int IRQ_MEI      = 11;

    // Writable-bit masks
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] MIP_SW_MASK  = 32'h0000_0008;
    localparam logic [31:0] ALIGN4_MASK  = 32'hFFFF_FFFC;

    // Trap cause codes
    localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;
    localparam logic [31:0] CAUSE_LOAD_FAULT   = 32'd5;
    localparam logic [31:0] CAUSE_STORE_FAULT  = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] CAUSE_M_TIMER_IRQ  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT_IRQ    = 32'h8000_000B;

    // Combine the old register value with the operand according to the access mode
    function automatic logic [31:0] csr_wsc(input logic [1:0] mode,
                                            input logic [31:0] old,
                                            input logic [31:0] operand);
        logic [31:0] v;
        case (mode)
            WSC_WRITE: v = operand;
            WSC_SET:   v = old | operand;
            WSC_CLEAR: v = old & ~operand;
            default:   v = old;
        endcase
        return v;
    endfunction

    function automatic logic csr_implemented(input logic [11:0] addr);
        logic hit;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MTIMECMP, CSR_MTIMECMPH,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID:
                hit = 1'b1;
            default:
                hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic csr_read_only(input logic [11:0] addr);
        return (addr == CSR_MISA) || (addr == CSR_MHARTID);
    endfunction

endpackage

// File: rtl/csr_file_m_counter64.sv
// rtl/csr_file_m_counter64.sv - 64-bit counter with per-half overwrite
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // A write to either half wins over the increment; the other half holds without carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR register file with timer and interrupt request
module csr_file_m
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_w,
    input  logic [1:0]  csr_wsc_mode,
    input  logic [11:0] raddr,
    input  logic [11:0] waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] mstatus,
    input  logic        ext_irq,
    input  logic        instret_inc,
    output logic        interrupt,
    output logic        illegal_csr
);

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic        msip_q;
    logic        mtip_q;
    logic        meip_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;
    logic        wr_en;
    logic [31:0] wr_old;
    logic [31:0] wr_new;

    // MPP is hardwired to machine mode
    assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
    assign mstatus     = mstatus_val;

    // Assemble mip from the software bit and the two hardware-driven pending bits
    always_comb begin
        mip_val          = '0;
        mip_val[IRQ_MSI] = msip_q;
        mip_val[IRQ_MTI] = mtip_q;
        mip_val[IRQ_MEI] = meip_q;
    end

    function automatic logic [31:0] csr_read(input logic [11:0] addr);
        logic [31:0] v;
        case (addr)
            CSR_MSTATUS:   v = mstatus_val;
            CSR_MISA:      v = MISA_VALUE;
            CSR_MIE:       v = mie_q;
            CSR_MTVEC:     v = mtvec_q;
            CSR_MSCRATCH:  v = mscratch_q;
            CSR_MEPC:      v = mepc_q;
            CSR_MCAUSE:    v = mcause_q;
            CSR_MTVAL:     v = mtval_q;
            CSR_MIP:       v = mip_val;
            CSR_MTIMECMP:  v = mtimecmp_q[31:0];
            CSR_MTIMECMPH: v = mtimecmp_q[63:32];
            CSR_MCYCLE:    v = mcycle[31:0];
            CSR_MCYCLEH:   v = mcycle[63:32];
            CSR_MINSTRET:  v = minstret[31:0];
            CSR_MINSTRETH: v = minstret[63:32];
            CSR_MHARTID:   v = HART_ID;
            default:       v = '0;
        endcase
        return v;
    endfunction

    assign rdata  = csr_read(raddr);
    assign wr_old = csr_read(waddr);
    assign wr_new = csr_wsc(csr_wsc_mode, wr_old, wdata);
    assign wr_en  = csr_w && (csr_wsc_mode != WSC_NONE)
                    && csr_implemented(waddr) && !csr_read_only(waddr);

    assign illegal_csr = !csr_implemented(raddr)
                         || (csr_w && (csr_wsc_mode != WSC_NONE)
                             && (!csr_implemented(waddr) || csr_read_only(waddr)));

    assign interrupt = mstatus_mie_q && |(mie_q & mip_val);

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_en && (waddr == CSR_MCYCLE)),
        .wr_hi (wr_en && (waddr == CSR_MCYCLEH)),
        .wdata (wr_new),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc),
        .wr_lo (wr_en && (waddr == CSR_MINSTRET)),
        .wr_hi (wr_en && (waddr == CSR_MINSTRETH)),
        .wdata (wr_new),
        .count (minstret)
    );

    // Trap CSR updates, plus the registered timer compare and external interrupt sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET & ALIGN4_MASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            msip_q         <= 1'b0;
            mtip_q         <= 1'b0;
            meip_q         <= 1'b0;
            mtimecmp_q     <= '1;
        end else begin
            mtip_q <= (mcycle >= mtimecmp_q);
            meip_q <= ext_irq;
            if (wr_en) begin
                case (waddr)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= wr_new[MSTATUS_MIE];
                        mstatus_mpie_q <= wr_new[MSTATUS_MPIE];
                    end
                    CSR_MIE:       mie_q               <= wr_new & MIE_MASK;
                    CSR_MTVEC:     mtvec_q             <= wr_new & ALIGN4_MASK;
                    CSR_MSCRATCH:  mscratch_q          <= wr_new;
                    CSR_MEPC:      mepc_q              <= wr_new & ALIGN4_MASK;
                    CSR_MCAUSE:    mcause_q            <= wr_new;
                    CSR_MTVAL:     mtval_q             <= wr_new;
                    CSR_MIP:       msip_q              <= wr_new[IRQ_MSI];
                    CSR_MTIMECMP:  mtimecmp_q[31:0]    <= wr_new;
                    CSR_MTIMECMPH: mtimecmp_q[63:32]   <= wr_new;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - scoreboard bench for csr_file_m against a behavioural CSR model
module tb_csr_file_m;

    localparam logic [31:0] P_MTVEC = 32'h0000_0000;
    localparam logic [31:0] P_MISA  = 32'h4000_0100;
    localparam logic [31:0] P_HART  = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic [11:0] raddr;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] mstatus;
    logic        ext_irq;
    logic        instret_inc;
    logic        interrupt;
    logic        illegal_csr;

    int total = 0;
    int bad   = 0;

    csr_file_m #(
        .MTVEC_RESET (P_MTVEC),
        .MISA_VALUE  (P_MISA),
        .HART_ID     (P_HART)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_w        (csr_w),
        .csr_wsc_mode (csr_wsc_mode),
        .raddr        (raddr),
        .waddr        (waddr),
        .wdata        (wdata),
        .rdata        (rdata),
        .mstatus      (mstatus),
        .ext_irq      (ext_irq),
        .instret_inc  (instret_inc),
        .interrupt    (interrupt),
        .illegal_csr  (illegal_csr)
    );

    always #5 clk = ~clk;

    // Reference model state: plain variables, 64-bit counters as integers
    bit [31:0] m_mstat, m_mie, m_mtvec, m_scr, m_epc, m_cause, m_tval;
    bit        m_msip, m_mtip, m_meip;
    bit [63:0] m_tcmp, m_cyc, m_ret;

    // Scoreboard queues
    string     q_name[$];
    bit [31:0] q_rd[$];
    bit        q_ill[$];
    bit        q_irq[$];
    bit [31:0] q_mst[$];

    function automatic void m_reset();
        m_mstat = 0; m_mie = 0; m_mtvec = P_MTVEC & ~32'h3; m_scr = 0; m_epc = 0;
        m_cause = 0; m_tval = 0; m_msip = 0; m_mtip = 0; m_meip = 0;
        m_tcmp = '1; m_cyc = 0; m_ret = 0;
    endfunction

    function automatic bit [31:0] m_mip();
        return (32'(m_msip) << 3) | (32'(m_mtip) << 7) | (32'(m_meip) << 11);
    endfunction

    function automatic bit [31:0] m_mstatus();
        return m_mstat | 32'h0000_1800;
    endfunction

    function automatic bit m_impl(bit [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'h344, 12'h7C0, 12'h7C1, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_writable(bit [11:0] a);
        return m_impl(a) && a != 12'h301 && a != 12'hF14;
    endfunction

    function automatic bit [31:0] m_read(bit [11:0] a);
        case (a)
            12'h300: return m_mstatus();
            12'h301: return P_MISA;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_mip();
            12'h7C0: return m_tcmp[31:0];
            12'h7C1: return m_tcmp[63:32];
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            12'hF14: return P_HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_irq();
        return m_mstat[3] && ((m_mie & m_mip()) != 0);
    endfunction

    // One rising edge of the model
    function automatic void m_edge(bit w, bit [1:0] md, bit [11:0] wa, bit [31:0] wd, bit ext, bit inc);
        bit        new_mtip = (m_cyc >= m_tcmp);
        bit        cyc_wr = 0;
        bit        ret_wr = 0;
        bit [31:0] old, nv;
        if (w && md != 2'b00 && m_writable(wa)) begin
            old = m_read(wa);
            nv = (md == 2'b01) ? wd : (md == 2'b10) ? (old | wd) : (old & ~wd);
            case (wa)
                12'h300: m_mstat = nv & 32'h88;
                12'h304: m_mie   = nv & 32'h888;
                12'h305: m_mtvec = nv & ~32'h3;
                12'h340: m_scr   = nv;
                12'h341: m_epc   = nv & ~32'h3;
                12'h342: m_cause = nv;
                12'h343: m_tval  = nv;
                12'h344: m_msip  = nv[3];
                12'h7C0: m_tcmp[31:0]  = nv;
                12'h7C1: m_tcmp[63:32] = nv;
                12'hB00: begin m_cyc[31:0]  = nv; cyc_wr = 1; end
                12'hB80: begin m_cyc[63:32] = nv; cyc_wr = 1; end
                12'hB02: begin m_ret[31:0]  = nv; ret_wr = 1; end
                12'hB82: begin m_ret[63:32] = nv; ret_wr = 1; end
                default: ;
            endcase
        end
        if (!cyc_wr) m_cyc = m_cyc + 1;
        if (!ret_wr && inc) m_ret = m_ret + 1;
        m_mtip = new_mtip;
        m_meip = ext;
    endfunction

    // Drive one cycle just after the rising edge, queue the expected outputs, then advance the model
    task automatic step(input bit w, input bit [1:0] md, input bit [11:0] ra, input bit [11:0] wa,
                        input bit [31:0] wd, input bit ext, input bit inc, input bit r, input string nm);
        bit ill;
        csr_w = w; csr_wsc_mode = md; raddr = ra; waddr = wa; wdata = wd;
        ext_irq = ext; instret_inc = inc; rst = r;
        if (r) m_reset();
        ill = !m_impl(ra) || (w && md != 2'b00 && !m_writable(wa));
        q_name.push_back(nm);
        q_rd.push_back(m_read(ra));
        q_ill.push_back(ill);
        q_irq.push_back(m_irq());
        q_mst.push_back(m_mstatus());
        @(posedge clk);
        if (!r) m_edge(w, md, wa, wd, ext, inc);
        #1;
    endtask

    task automatic idle(input bit [11:0] ra, input bit ext, input string nm);
        step(1'b0, 2'b00, ra, 12'h000, 32'h0, ext, 1'b0, 1'b0, nm);
    endtask

    task automatic wr(input bit [1:0] md, input bit [11:0] wa, input bit [31:0] wd,
                      input bit [11:0] ra, input string nm);
        step(1'b1, md, ra, wa, wd, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic chk(input string nm, input bit [31:0] got, input bit [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation in mid-cycle
    initial begin
        string nm;
        forever begin
            @(negedge clk);
            if (q_name.size() > 0) begin
                nm = q_name.pop_front();
                chk({nm, ".rdata"},   rdata,                 q_rd.pop_front());
                chk({nm, ".illegal"}, {31'd0, illegal_csr},  {31'd0, q_ill.pop_front()});
                chk({nm, ".irq"},     {31'd0, interrupt},    {31'd0, q_irq.pop_front()});
                chk({nm, ".mstatus"}, mstatus,               q_mst.pop_front());
            end
        end
    end

    logic [11:0] addr_tab [0:17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                     12'h342, 12'h343, 12'h344, 12'h7C0, 12'h7C1, 12'hB00,
                                     12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7FF, 12'h123};

    initial begin
        csr_w = 0; csr_wsc_mode = 0; raddr = 12'h300; waddr = 0; wdata = 0;
        ext_irq = 0; instret_inc = 0; rst = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset values and unimplemented read
        idle(12'h300, 0, "rst_mstatus");
        idle(12'h305, 0, "rst_mtvec");
        idle(12'hF14, 0, "rst_hartid");
        idle(12'h7FF, 0, "unimpl_read");

        // Write/set/clear and field masks
        wr(2'b01, 12'h340, 32'hF0F0_0000, 12'h340, "scr_write");
        wr(2'b10, 12'h340, 32'h0000_000F, 12'h340, "scr_set");
        wr(2'b11, 12'h340, 32'hF000_0000, 12'h340, "scr_clear");
        idle(12'h340, 0, "scr_result");
        wr(2'b01, 12'h304, 32'hFFFF_FFFF, 12'h304, "mie_write");
        idle(12'h304, 0, "mie_mask");
        wr(2'b01, 12'h341, 32'h1234_5677, 12'h341, "mepc_write");
        wr(2'b01, 12'h344, 32'hFFFF_FFFF, 12'h344, "mip_write");
        idle(12'h344, 0, "mip_mask");
        wr(2'b11, 12'h344, 32'hFFFF_FFFF, 12'h344, "mip_clear");

        // mcycle low write followed by carry into the high half
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 12'hB80, "mcycle_wr");
        idle(12'hB00, 0, "mcycle_lo_full");
        idle(12'hB00, 0, "mcycle_lo_wrap");
        idle(12'hB80, 0, "mcycle_hi_carry");
        wr(2'b01, 12'hF14, 32'h1111_1111, 12'h300, "hartid_write");
        idle(12'hF14, 0, "hartid_keep");
        wr(2'b01, 12'h7FF, 32'h1, 12'h300, "unimpl_write");

        // Timer interrupt from a fresh reset
        step(0, 2'b00, 12'h300, 12'h0, 32'h0, 0, 0, 1, "timer_reset");
        wr(2'b01, 12'h7C0, 32'd20, 12'h7C0, "tcmp_lo");
        wr(2'b01, 12'h7C1, 32'd0,  12'h7C1, "tcmp_hi");
        wr(2'b01, 12'h304, 32'h80, 12'h304, "mtie");
        wr(2'b01, 12'h300, 32'h8,  12'h300, "mstatus_mie");
        for (int i = 0; i < 22; i++) idle(12'h344, 0, "timer_wait");
        wr(2'b01, 12'h7C1, 32'hFFFF_FFFF, 12'h344, "tcmp_raise_hi");
        wr(2'b01, 12'h7C0, 32'hFFFF_FFFF, 12'h344, "tcmp_raise_lo");
        for (int i = 0; i < 3; i++) idle(12'h344, 0, "timer_clear");

        // External interrupt masked by mstatus.MIE, then enabled
        wr(2'b11, 12'h300, 32'h8,   12'h300, "mie_off");
        wr(2'b01, 12'h304, 32'h800, 12'h304, "meie");
        idle(12'h344, 1, "ext_rise");
        idle(12'h344, 1, "ext_masked");
        step(1, 2'b10, 12'h344, 12'h300, 32'h8, 1, 0, 0, "mie_on");
        idle(12'h344, 1, "ext_irq_on");
        idle(12'h344, 0, "ext_drop");
        idle(12'h344, 0, "ext_gone");

        // Reset during back-to-back mepc writes
        wr(2'b01, 12'h341, 32'h0000_1234, 12'h341, "mepc_a");
        step(1, 2'b01, 12'h341, 12'h341, 32'h0000_5678, 0, 0, 1, "mepc_rst");
        idle(12'h341, 0, "mepc_after_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 addr_tab[$urandom_range(0, 17)], addr_tab[$urandom_range(0, 17)],
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 99) == 0), "rand");
        end
        idle(12'h300, 0, "final");

        for (int i = 0; i < 5 && q_name.size() > 0; i++) @(negedge clk);
        if (q_name.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", q_name.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_file_m.md
# csr_file_m

Machine-mode CSR register file that acts as the responder on the CSR access port driven by the exception unit and the pipeline's CSR instructions. It holds the trap CSRs (mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip), 64-bit cycle and instret counters, and a machine timer compare register. From this state it generates the interrupt request back to the exception unit. Reads are combinational; all state updates occur on the rising clock edge.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits 1:0 forced 0)
- MISA_VALUE, 32'h4000_0100, constant misa (RV32I)
- HART_ID, 32'h0, constant mhartid

- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- csr_w  in  1  write strobe for this cycle
- csr_wsc_mode  in  2  01 write, 10 set (old|wdata), 11 clear (old&~wdata), 00 no-op
- raddr  in  12  read address
- waddr  in  12  write address
- wdata  in  32  write operand
- rdata  out  32  combinational read of raddr; 0 for unimplemented addresses
- mstatus  out  32  current mstatus
- ext_irq  in  1  level external interrupt
- instret_inc  in  1  one instruction retired this cycle
- interrupt  out  1  mstatus.MIE & |(mie & mip)
- illegal_csr  out  1  combinational: raddr unimplemented, or csr_w with a nonzero mode to an unimplemented or read-only waddr

## Operation
- Implemented CSRs:
  - mstatus 0x300:
    - MIE bit 3 and MPIE bit 7 writable.
    - MPP bits 12:11 read 2'b11.
    - All other bits read 0.
  - misa 0x301: read-only, MISA_VALUE.
  - mie 0x304: bits 3, 7 and 11 writable; all other bits 0.
  - mtvec 0x305: bits 1:0 are 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits 1:0 are 0.
  - mcause 0x342: full 32 bits.
  - mtval 0x343: full 32 bits.
  - mip 0x344:
    - Only MSIP (bit 3) is writable.
    - MTIP (bit 7) and MEIP (bit 11) are hardware-driven; writes to them are ignored.
  - mtimecmp 0x7C0 (low word) and 0x7C1 (high word): read/write.
  - mcycle 0xB00/0xB80 and minstret 0xB02/0xB82: read/write, low/high halves.
  - mhartid 0xF14: read-only, HART_ID.
- Write value:
  - new = f(mode, old, wdata), then the per-register mask is applied.
  - Writes to read-only or unimplemented addresses are dropped.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instret_inc is high.
  - Both wrap modulo 2^64.
  - A CSR write to either half takes priority over the increment in that cycle. The other half holds; there is no carry into it that cycle.
- MTIP: registered value of (mcycle >= mtimecmp), 64-bit unsigned compare.
- MEIP: ext_irq registered once, giving 1 cycle of latency.
- interrupt: combinational from the registered state listed above.

## Timing
- Reset values (asynchronous):
  - mstatus = 32'h0000_1800
  - mtvec = MTVEC_RESET & ~3
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - All other registers 0.
  - interrupt = 0, illegal_csr = 0 (for an implemented raddr).
- Write latency: a write sampled at edge N is visible on rdata and mstatus after edge N.
- Same-cycle raddr == waddr returns the old value; there is no bypass.
- Reads have no side effects.
- Timer interrupt: if mcycle reaches mtimecmp at edge N, MTIP rises after edge N+1.
- Writing mtimecmp above mcycle clears MTIP one edge after the write.
- External interrupt: ext_irq rising before edge N sets MEIP after edge N; interrupt follows combinationally.
- Reset mid-operation: all state returns to reset values immediately; writes in flight are lost.

## Structure
- Shared package csr_pkg, used by this block and the exception unit, holds:
  - CSR address localparams
  - wsc mode encodings
  - mstatus/mip/mie bit indices
  - mcause codes: 2, 5, 7, 11, plus 32'h8000_0007 and 32'h8000_000B
- Sub-module csr_counter64:
  - 64-bit counter with inc, wr_lo/wr_hi, wdata.
  - Instantiated for mcycle and minstret.
- Expected size: 200–300 lines of RTL.

## Test plan
- Reset then read 0x300, 0x305, 0xF14 → 32'h0000_1800, MTVEC_RESET, HART_ID; read 0x7FF → 0 with illegal_csr = 1.
- Write mscratch 32'hF0F0_0000 (mode 01), set 32'h0000_000F (10), clear 32'hF000_0000 (11) → reads back 32'h00F0_000F; a write to mie of 32'hFFFF_FFFF reads back 32'h0000_0888.
- Write 32'hFFFF_FFFF to mcycle low → next cycle low = 0 and high incremented by 1; write to mhartid → dropped, illegal_csr = 1.
- mtimecmp = 20, mie.MTIE = 1, mstatus.MIE = 1 → interrupt rises once mcycle ≥ 20 (one edge after); rewrite mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF → interrupt clears the edge after MTIP updates.
- ext_irq pulse with mie.MEIE = 1 and mstatus.MIE = 0 → MEIP = 1, interrupt = 0; set MIE → interrupt = 1 the cycle after.
- Assert rst during back-to-back mepc writes → mepc = 0 immediately and the pending write is not applied.
